// File: rtl/alu_pkg.sv
// Shared op-code fields, FSM encoding and flag bundle for the pipelined ALU.
package alu_pkg;

  // FUN[3:2] op class
  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

  // FUN[1:0] op within class
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_EQ   = 2'b01;
  localparam logic [1:0] OP_GT   = 2'b10;
  localparam logic [1:0] OP_LT   = 2'b11;

  localparam logic [1:0] OP_SHRA = 2'b00;
  localparam logic [1:0] OP_SHLA = 2'b01;
  localparam logic [1:0] OP_SHRB = 2'b10;
  localparam logic [1:0] OP_SHLB = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DIV_RUN = 1'b1
  } state_e;

  typedef struct packed {
    logic div0;
    logic carry;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider, one quotient bit per cycle. The final iteration's
// quotient/remainder are presented combinationally alongside done_o so the
// caller can register them on the same edge.
module alu_div_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [W:0]    shl;
  logic [W-1:0]  sub;
  logic          brw;
  logic [W-1:0]  rem_d, quo_d;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shl   = {rem_q, quo_q[W-1]};
    brw   = shl < {1'b0, dvs_q};
    sub   = W'(shl - {1'b0, dvs_q});
    rem_d = brw ? shl[W-1:0] : sub;
    quo_d = {quo_q[W-2:0], ~brw};
  end

  assign busy_o = busy_q;
  assign done_o = busy_q & (cnt_q == CW'(W-1));
  assign quot_o = quo_d;
  assign rem_o  = rem_d;

  // Load operands on start, then iterate W times; reset aborts any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= a_i;
      dvs_q  <= b_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU: single-cycle ops plus iterative divide, with a held
// output register that only reloads when empty or being drained.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2*IN_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  input  logic [3:0]           FUN,
  output logic [OUT_WIDTH-1:0] ALU_OUT,
  output logic                 OUT_ZERO,
  output logic                 OUT_CARRY,
  output logic                 OUT_DIV0,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
);

  localparam int XW = OUT_WIDTH + 1;

  state_e               state_q;
  logic [OUT_WIDTH-1:0] out_q;
  alu_flags_t           flags_q, flags_d;
  logic                 valid_q;

  logic [XW-1:0]        add_x, sub_x;
  logic [IN_WIDTH-1:0]  and_v, or_v, nand_v, nor_v;
  logic [OUT_WIDTH-1:0] res_d, load_val;
  logic                 carry_d, div0_d;
  logic                 accept, drain, is_div, b_zero, div_go, load;
  logic                 div_busy, div_done;
  logic [IN_WIDTH-1:0]  div_quot, div_rem;

  assign add_x  = XW'(A) + XW'(B);
  assign sub_x  = XW'(A) - XW'(B);
  assign and_v  = A & B;
  assign or_v   = A | B;
  assign nand_v = ~and_v;
  assign nor_v  = ~or_v;

  // Single-cycle result mux; DIV here only covers the divide-by-zero shortcut.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    div0_d  = 1'b0;
    case (FUN[3:2])
      CLS_ARITH: case (FUN[1:0])
        OP_ADD: begin res_d = add_x[OUT_WIDTH-1:0]; carry_d = add_x[OUT_WIDTH]; end
        OP_SUB: begin res_d = sub_x[OUT_WIDTH-1:0]; carry_d = sub_x[OUT_WIDTH]; end
        OP_MUL: res_d = OUT_WIDTH'(A) * OUT_WIDTH'(B);
        default: begin
          res_d  = OUT_WIDTH'({A, {IN_WIDTH{1'b1}}});
          div0_d = 1'b1;
        end
      endcase
      CLS_LOGIC: case (FUN[1:0])
        OP_AND:  res_d = OUT_WIDTH'(and_v);
        OP_OR:   res_d = OUT_WIDTH'(or_v);
        OP_NAND: res_d = OUT_WIDTH'(nand_v);
        default: res_d = OUT_WIDTH'(nor_v);
      endcase
      CLS_CMP: case (FUN[1:0])
        OP_NOP:  res_d = '0;
        OP_EQ:   res_d = (A == B) ? OUT_WIDTH'(1) : '0;
        OP_GT:   res_d = (A > B)  ? OUT_WIDTH'(2) : '0;
        default: res_d = (A < B)  ? OUT_WIDTH'(3) : '0;
      endcase
      default: case (FUN[1:0])
        OP_SHRA: res_d = OUT_WIDTH'(A >> 1);
        OP_SHLA: res_d = OUT_WIDTH'({A, 1'b0});
        OP_SHRB: res_d = OUT_WIDTH'(B >> 1);
        default: res_d = OUT_WIDTH'({B, 1'b0});
      endcase
    endcase
  end

  assign IN_READY = ~RST & (state_q == ST_IDLE) & ~div_busy & (~valid_q | OUT_READY);
  assign accept   = IN_VALID & IN_READY;
  assign drain    = valid_q & OUT_READY;
  assign is_div   = (FUN == {CLS_ARITH, OP_DIV});
  assign b_zero   = (B == '0);
  assign div_go   = accept & is_div & ~b_zero;
  assign load     = (accept & ~div_go) | div_done;
  assign load_val = div_done ? OUT_WIDTH'({div_rem, div_quot}) : res_d;

  always_comb begin
    flags_d.div0  = ~div_done & div0_d;
    flags_d.carry = ~div_done & carry_d;
    flags_d.zero  = (load_val == '0);
  end

  alu_div_iter #(.W(IN_WIDTH)) u_div (
    .clk     (CLK),
    .rst     (RST),
    .start_i (div_go),
    .a_i     (A),
    .b_i     (B),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (div_quot),
    .rem_o   (div_rem)
  );

  // Control FSM plus output register: load on completion, clear on bare drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:    if (div_go)   state_q <= ST_DIV_RUN;
        ST_DIV_RUN: if (div_done) state_q <= ST_IDLE;
        default:                  state_q <= ST_IDLE;
      endcase
      if (load) begin
        out_q   <= load_val;
        flags_q <= flags_d;
        valid_q <= 1'b1;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ALU_OUT   = out_q;
  assign OUT_ZERO  = flags_q.zero;
  assign OUT_CARRY = flags_q.carry;
  assign OUT_DIV0  = flags_q.div0;
  assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and scoreboarded checks for alu_pipe (IN_WIDTH=8, OUT_WIDTH=16).
module tb_alu_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, IN_READY;
  logic [7:0]  A, B;
  logic [3:0]  FUN;
  logic [15:0] ALU_OUT;
  logic        OUT_ZERO, OUT_CARRY, OUT_DIV0, OUT_VALID, OUT_READY;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .FUN       (FUN),
    .ALU_OUT   (ALU_OUT),
    .OUT_ZERO  (OUT_ZERO),
    .OUT_CARRY (OUT_CARRY),
    .OUT_DIV0  (OUT_DIV0),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  // Reference: {div0, carry, zero, result}
  function automatic logic [18:0] model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic c, d;
    int ai, bi;
    ai = int'(a); bi = int'(b);
    r = '0; c = 1'b0; d = 1'b0;
    case (f)
      4'h0: r = 16'(ai + bi);
      4'h1: begin r = 16'(ai - bi); c = (ai < bi); end
      4'h2: r = 16'(ai * bi);
      4'h3: if (bi == 0) begin r = {a, 8'hFF}; d = 1'b1; end
            else r = {8'(ai % bi), 8'(ai / bi)};
      4'h4: r = {8'h00, a & b};
      4'h5: r = {8'h00, a | b};
      4'h6: r = {8'h00, ~(a & b)};
      4'h7: r = {8'h00, ~(a | b)};
      4'h8: r = 16'h0000;
      4'h9: r = (a == b) ? 16'd1 : 16'd0;
      4'hA: r = (a > b)  ? 16'd2 : 16'd0;
      4'hB: r = (a < b)  ? 16'd3 : 16'd0;
      4'hC: r = {9'h000, a[7:1]};
      4'hD: r = {7'h00, a, 1'b0};
      4'hE: r = {9'h000, b[7:1]};
      default: r = {7'h00, b, 1'b0};
    endcase
    return {d, c, (r == 16'h0000), r};
  endfunction

  // Present one request and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    @(negedge CLK);
    IN_VALID = 1'b1; FUN = f; A = a; B = b;
    #1;
    while (!IN_READY && n < 200) begin
      @(negedge CLK); #1; n++;
    end
    ok = IN_READY;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain_one();
    @(negedge CLK); OUT_READY = 1'b1;
    @(posedge CLK); #1; OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    repeat (2) @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0 || ALU_OUT !== 16'h0 || {OUT_ZERO, OUT_CARRY, OUT_DIV0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b vld=%b out=%h flags=%b, want 0 0 0000 000", IN_READY, OUT_VALID, ALU_OUT, {OUT_ZERO, OUT_CARRY, OUT_DIV0});
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_release: rdy=%b vld=%b, want 1 0", IN_READY, OUT_VALID);
    end
    // abort a divide in flight
    send(4'h3, 8'd200, 8'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_div_accept: timeout, want accept"); end
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b1; #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0 || ALU_OUT !== 16'h0) begin
      errors++; $display("FAIL reset_mid_div: vld=%b rdy=%b out=%h, want 0 0 0000", OUT_VALID, IN_READY, ALU_OUT);
    end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || ALU_OUT !== 16'h0) begin
      errors++; $display("FAIL reset_after_abort: rdy=%b vld=%b out=%h, want 1 0 0000", IN_READY, OUT_VALID, ALU_OUT);
    end
    n = 0;
    repeat (12) begin @(posedge CLK); #1; if (OUT_VALID !== 1'b0) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL reset_no_partial: valid seen %0d cycles, want 0", n); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  f[6]  = '{4'h0,    4'h1,    4'h2,    4'hA,    4'hD,    4'h4};
    logic [7:0]  a[6]  = '{8'hFF,   8'd3,    8'hFF,   8'd9,    8'h80,   8'h0F};
    logic [7:0]  b[6]  = '{8'h01,   8'd5,    8'hFF,   8'd4,    8'h00,   8'hF0};
    logic [15:0] e[6]  = '{16'h0100,16'hFFFE,16'hFE01,16'h0002,16'h0100,16'h0000};
    logic        ec[6] = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};
    logic        ez[6] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
    bit ok;
    for (int i = 0; i < 6; i++) begin
      send(f[i], a[i], b[i], ok);
      checks++;
      if (!ok || OUT_VALID !== 1'b1 || ALU_OUT !== e[i] || OUT_CARRY !== ec[i] || OUT_ZERO !== ez[i] || OUT_DIV0 !== 1'b0) begin
        errors++;
        $display("FAIL op_%0d fun=%h: ok=%b vld=%b out=%h c=%b z=%b d=%b, want 1 %h c=%b z=%b d=0",
                 i, f[i], ok, OUT_VALID, ALU_OUT, OUT_CARRY, OUT_ZERO, OUT_DIV0, e[i], ec[i], ez[i]);
      end
      drain_one();
      checks++;
      if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL drain_clear_%0d: vld=%b, want 0", i, OUT_VALID); end
    end
  endtask

  task automatic test_div();
    bit ok;
    send(4'h3, 8'd100, 8'd7, ok);
    checks++;
    if (!ok || IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL div_start: ok=%b rdy=%b vld=%b, want 1 0 0", ok, IN_READY, OUT_VALID);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (i < 8) begin
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0) begin
          errors++; $display("FAIL div_run_%0d: vld=%b rdy=%b, want 0 0", i, OUT_VALID, IN_READY);
        end
      end else if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h020E || OUT_DIV0 !== 1'b0 || OUT_CARRY !== 1'b0 || OUT_ZERO !== 1'b0) begin
        errors++; $display("FAIL div_result: vld=%b out=%h d=%b c=%b z=%b, want 1 020e 0 0 0", OUT_VALID, ALU_OUT, OUT_DIV0, OUT_CARRY, OUT_ZERO);
      end
    end
    drain_one();
    send(4'h3, 8'h2A, 8'h00, ok);
    checks++;
    if (!ok || OUT_VALID !== 1'b1 || ALU_OUT !== 16'h2AFF || OUT_DIV0 !== 1'b1 || IN_READY !== 1'b0) begin
      errors++; $display("FAIL div0: ok=%b vld=%b out=%h d=%b rdy=%b, want 1 1 2aff 1 0", ok, OUT_VALID, ALU_OUT, OUT_DIV0, IN_READY);
    end
    drain_one();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    send(4'h4, 8'hF0, 8'h3C, ok);
    bad = ok ? 0 : 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h0030 || IN_READY !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL backpressure_hold: %0d bad cycles, vld=%b out=%h rdy=%b, want 1 0030 0", bad, OUT_VALID, ALU_OUT, IN_READY);
    end
    @(negedge CLK);
    IN_VALID = 1'b1; FUN = 4'h5; A = 8'hF0; B = 8'h0F; OUT_READY = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL no_bubble_ready: rdy=%b, want 1", IN_READY); end
    @(posedge CLK); #1;
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h00FF) begin
      errors++; $display("FAIL no_bubble_result: vld=%b out=%h, want 1 00ff", OUT_VALID, ALU_OUT);
    end
    drain_one();
  endtask

  task automatic test_stream();
    logic [18:0] exp_q[$];
    int got;
    got = 0;
    fork
      begin
        bit ok;
        logic [3:0] f;
        logic [7:0] a, b;
        for (int i = 0; i < 20; i++) begin
          f = 4'($urandom_range(0, 15));
          a = 8'($urandom);
          b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
          send(f, a, b, ok);
          if (!ok) begin
            checks++; errors++; $display("FAIL stream_accept_%0d: timeout", i);
            break;
          end
          exp_q.push_back(model(f, a, b));
        end
      end
      begin
        logic [18:0] exp;
        int cyc;
        cyc = 0;
        while (got < 20 && cyc < 3000) begin
          @(negedge CLK);
          OUT_READY = 1'($urandom_range(0, 1));
          #1;
          if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL stream_extra: out=%h with no pending op", ALU_OUT);
            end else begin
              exp = exp_q.pop_front();
              if ({OUT_DIV0, OUT_CARRY, OUT_ZERO, ALU_OUT} !== exp) begin
                errors++; $display("FAIL stream_%0d: got d/c/z/out=%b%b%b %h, want %b %h",
                                   got, OUT_DIV0, OUT_CARRY, OUT_ZERO, ALU_OUT, exp[18:16], exp[15:0]);
              end
            end
            got++;
          end
          cyc++;
        end
        @(negedge CLK); OUT_READY = 1'b0;
      end
    join
    checks++;
    if (got != 20 || exp_q.size() != 0) begin
      errors++; $display("FAIL stream_count: drained %0d pending %0d, want 20 0", got, exp_q.size());
    end
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; FUN = '0;
    test_reset();
    test_single_cycle();
    test_div();
    test_back_to_back();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
